// File: rtl/smallcpu_pkg.sv
// Shared definitions for the small CPU data path: port ids, arbiter state
// encoding and the default word width / memory depth.
package smallcpu_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned MEM_DEPTH = 1024;

    // Requester ids, also used as the round-robin "last winner" value.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Data-memory arbiter lock state: IDLE means unlocked, otherwise the owner.
    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_LOCKED_A = 2'd1,
        ARB_LOCKED_B = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: stateless 2-way round-robin picker.
// Ports: req[1:0] (bit 0 = port A, bit 1 = port B), last (id of the previous
//        winner), gnt[1:0] one-hot grant or zero when nobody requests.
module rr_arb2
    import smallcpu_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On a tie the port that did not win last time goes first.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | (last == PORT_B));
        gnt[1] = req[1] & (~req[0] | (last == PORT_A));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between port A (CPU) and
// port B (loader/debug DMA) with round-robin arbitration, an optional bounded
// bus lock and 1-cycle read-data return routing.
// Ports: clk, rst (sync, active high); per port: req, we, lock, addr, wdata
//        in, gnt, rvalid, rdata out; memory side: mem_addr, mem_wdata, mem_we
//        out, mem_rdata in (valid one cycle after the address).
module dmem_arbiter
    import smallcpu_pkg::*;
#(
    parameter int unsigned N        = DATA_W,
    parameter int unsigned M        = MEM_DEPTH,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic                 a_lock,
    input  logic [N-1:0]         a_addr,
    input  logic [N-1:0]         a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [N-1:0]         a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic                 b_lock,
    input  logic [N-1:0]         b_addr,
    input  logic [N-1:0]         b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [N-1:0]         b_rdata,
    output logic [$clog2(M)-1:0] mem_addr,
    output logic [N-1:0]         mem_wdata,
    output logic                 mem_we,
    input  logic [N-1:0]         mem_rdata
);

    localparam int unsigned AW = $clog2(M);
    localparam int unsigned CW = $clog2(MAX_LOCK + 1);

    arb_state_t    state, state_next;
    logic [CW-1:0] lock_cnt, lock_cnt_next;
    logic          last_winner;
    logic          rd_pend;
    logic          rd_dst;
    logic [1:0]    rr_gnt;
    logic          use_rr;

    // Address bits above the memory depth are ignored (addresses wrap).
    logic          unused_addr_bits;
    assign unused_addr_bits = ^{a_addr[N-1:AW], b_addr[N-1:AW]};

    rr_arb2 u_rr (
        .req  ({b_req, a_req}),
        .last (last_winner),
        .gnt  (rr_gnt)
    );

    // Lock FSM next state and combinational grants.
    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        a_gnt         = 1'b0;
        b_gnt         = 1'b0;
        use_rr        = 1'b0;

        unique case (state)
            ARB_LOCKED_A: begin
                if (!a_req) begin
                    use_rr = 1'b1;
                end else if (b_req && (lock_cnt == CW'(MAX_LOCK))) begin
                    // Hold budget spent: hand this cycle to B and unlock.
                    b_gnt         = 1'b1;
                    state_next    = ARB_IDLE;
                    lock_cnt_next = '0;
                end else begin
                    a_gnt = 1'b1;
                    if (a_lock) begin
                        state_next = ARB_LOCKED_A;
                        if (b_req) lock_cnt_next = lock_cnt + CW'(1);
                    end else begin
                        state_next    = ARB_IDLE;
                        lock_cnt_next = '0;
                    end
                end
            end
            ARB_LOCKED_B: begin
                if (!b_req) begin
                    use_rr = 1'b1;
                end else if (a_req && (lock_cnt == CW'(MAX_LOCK))) begin
                    a_gnt         = 1'b1;
                    state_next    = ARB_IDLE;
                    lock_cnt_next = '0;
                end else begin
                    b_gnt = 1'b1;
                    if (b_lock) begin
                        state_next = ARB_LOCKED_B;
                        if (a_req) lock_cnt_next = lock_cnt + CW'(1);
                    end else begin
                        state_next    = ARB_IDLE;
                        lock_cnt_next = '0;
                    end
                end
            end
            default: use_rr = 1'b1;
        endcase

        // Unlocked arbitration; a winner asking for lock takes ownership.
        if (use_rr) begin
            a_gnt = rr_gnt[0];
            b_gnt = rr_gnt[1];
            if (rr_gnt[0] && a_lock) begin
                state_next    = ARB_LOCKED_A;
                lock_cnt_next = CW'(1);
            end else if (rr_gnt[1] && b_lock) begin
                state_next    = ARB_LOCKED_B;
                lock_cnt_next = CW'(1);
            end else begin
                state_next    = ARB_IDLE;
                lock_cnt_next = '0;
            end
        end

        // No access is performed while reset is held.
        if (rst) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
        end
    end

    // State, round-robin history and read-return pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            lock_cnt    <= '0;
            last_winner <= PORT_B;
            rd_pend     <= 1'b0;
            rd_dst      <= PORT_A;
        end else begin
            state    <= state_next;
            lock_cnt <= lock_cnt_next;
            if (a_gnt || b_gnt) last_winner <= b_gnt ? PORT_B : PORT_A;
            rd_pend <= (a_gnt & ~a_we) | (b_gnt & ~b_we);
            rd_dst  <= b_gnt ? PORT_B : PORT_A;
        end
    end

    // Memory port follows the granted requester; idle bus is all zero.
    assign mem_we    = (a_gnt & a_we) | (b_gnt & b_we);
    assign mem_addr  = a_gnt ? a_addr[AW-1:0] : (b_gnt ? b_addr[AW-1:0] : '0);
    assign mem_wdata = a_gnt ? a_wdata : (b_gnt ? b_wdata : '0);

    // Read data is steered to the port that issued the read; rst drops it.
    assign a_rvalid = rd_pend & (rd_dst == PORT_A) & ~rst;
    assign b_rvalid = rd_pend & (rd_dst == PORT_B) & ~rst;
    assign a_rdata  = a_rvalid ? mem_rdata : '0;
    assign b_rdata  = b_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table-driven grant vectors plus hand sequences for
// lock, lock release and reset, with a scoreboard for read returns.
module tb_dmem_arbiter;

    localparam int unsigned N  = 16;
    localparam int unsigned M  = 1024;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [N-1:0]  a_addr, a_wdata, b_addr, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [N-1:0]  a_rdata, b_rdata;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_wdata, mem_rdata;
    logic          mem_we;

    logic [N-1:0]  mem     [M];
    logic [N-1:0]  ref_mem [M];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        port;
        logic [N-1:0] data;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic         a_req, a_we, a_lock;
        logic [N-1:0] a_addr, a_wdata;
        logic         b_req, b_we, b_lock;
        logic [N-1:0] b_addr, b_wdata;
        logic         exp_a, exp_b;
        string        name;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    dmem_arbiter #(.N(N), .M(M), .MAX_LOCK(8)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Behavioural single-port memory, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare one cycle at the negedge, then record this cycle's expected grant.
    task automatic check_cycle(input logic ea, input logic eb, input string name);
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [N-1:0]  exp_wd, exp_ad, exp_bd;
        logic          exp_av, exp_bv;
        sb_t           e;
        exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
        exp_av = 1'b0; exp_bv = 1'b0; exp_ad = '0; exp_bd = '0;
        if (rst) sb.delete();
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port) begin exp_bv = 1'b1; exp_bd = e.data; end
            else        begin exp_av = 1'b1; exp_ad = e.data; end
        end
        if (ea) begin
            exp_we = a_we; exp_addr = a_addr[AW-1:0]; exp_wd = a_wdata;
        end else if (eb) begin
            exp_we = b_we; exp_addr = b_addr[AW-1:0]; exp_wd = b_wdata;
        end
        cmp({name, "/gnt"}, 64'({a_gnt, b_gnt}), 64'({ea, eb}));
        cmp({name, "/mem"}, 64'({mem_we, mem_addr, mem_wdata}), 64'({exp_we, exp_addr, exp_wd}));
        cmp({name, "/rd"}, 64'({a_rvalid, a_rdata, b_rvalid, b_rdata}),
            64'({exp_av, exp_ad, exp_bv, exp_bd}));
        if (ea || eb) begin
            if (exp_we) ref_mem[exp_addr] = exp_wd;
            else sb.push_back('{port: eb, data: ref_mem[exp_addr]});
        end
    endtask

    task automatic run_cycle(input logic ea, input logic eb, input string name);
        @(negedge clk);
        check_cycle(ea, eb, name);
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic req, input logic we, input logic lock,
                         input logic [N-1:0] addr, input logic [N-1:0] wd);
        a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic lock,
                         input logic [N-1:0] addr, input logic [N-1:0] wd);
        b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = wd;
    endtask

    function automatic vec_t mkv(input logic ar, input logic aw, input logic [N-1:0] aa,
                                 input logic [N-1:0] ad, input logic br, input logic bw,
                                 input logic [N-1:0] ba, input logic [N-1:0] bd,
                                 input logic ea, input logic eb, input string name);
        vec_t v;
        v.a_req = ar; v.a_we = aw; v.a_lock = 1'b0; v.a_addr = aa; v.a_wdata = ad;
        v.b_req = br; v.b_we = bw; v.b_lock = 1'b0; v.b_addr = ba; v.b_wdata = bd;
        v.exp_a = ea; v.exp_b = eb; v.name = name;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < M; i++) begin
            mem[i]     = N'(16'h1000 + i);
            ref_mem[i] = N'(16'h1000 + i);
        end

        // Tie after reset, then alternation, write/readback with wrap, edges.
        vecs.push_back(mkv(1, 0, 16'd5, 0, 1, 0, 16'd6, 0, 1, 0, "t1_tie"));
        vecs.push_back(mkv(0, 0, 0, 0, 1, 0, 16'd6, 0, 0, 1, "t1_b"));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mkv(1, 0, 16'd10, 0, 1, 0, 16'd20, 0,
                               (i % 2) == 0, (i % 2) == 1, "t2_rr"));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle"));
        vecs.push_back(mkv(1, 1, 16'd1027, 16'hBEEF, 0, 0, 0, 0, 1, 0, "t3_wr"));
        vecs.push_back(mkv(0, 0, 0, 0, 1, 0, 16'd3, 0, 0, 1, "t3_rd"));
        vecs.push_back(mkv(1, 0, 16'h0400, 0, 0, 0, 0, 0, 1, 0, "wrap0"));
        vecs.push_back(mkv(0, 0, 0, 0, 1, 0, 16'hFFFF, 0, 0, 1, "wrapmax"));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle2"));

        // Reset with both ports requesting: no grant, bus quiet.
        rst = 1'b1;
        set_a(1, 0, 0, 16'd1, 0);
        set_b(1, 0, 0, 16'd2, 0);
        run_cycle(0, 0, "reset0");
        run_cycle(0, 0, "reset1");
        rst = 1'b0;

        foreach (vecs[i]) begin
            set_a(vecs[i].a_req, vecs[i].a_we, vecs[i].a_lock, vecs[i].a_addr, vecs[i].a_wdata);
            set_b(vecs[i].b_req, vecs[i].b_we, vecs[i].b_lock, vecs[i].b_addr, vecs[i].b_wdata);
            run_cycle(vecs[i].exp_a, vecs[i].exp_b, vecs[i].name);
        end

        // A holds lock against a busy B: 8 A grants, one B grant, then re-lock.
        set_a(1, 0, 1, 16'd100, 0);
        set_b(1, 0, 0, 16'd200, 0);
        for (int i = 0; i < 20; i++)
            run_cycle(!(i == 8 || i == 17), (i == 8 || i == 17), "t4_lock");

        // Same lock with B idle: A keeps every grant.
        set_b(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            run_cycle(1, 0, "t4_solo");

        // Locked A drops req while B requests: B served in that same cycle.
        set_a(0, 0, 1, 16'd100, 0);
        set_b(1, 0, 0, 16'd201, 0);
        run_cycle(0, 1, "t5_release");
        set_a(1, 0, 0, 16'd101, 0);
        set_b(1, 0, 0, 16'd202, 0);
        run_cycle(1, 0, "t5_after");
        set_a(0, 0, 0, 0, 0);
        run_cycle(0, 1, "t5_b");

        // Reset right after a granted A read: return dropped, tie goes to A.
        set_a(1, 0, 0, 16'd7, 0);
        set_b(0, 0, 0, 0, 0);
        run_cycle(1, 0, "t6_rd");
        rst = 1'b1;
        set_b(1, 0, 0, 16'd8, 0);
        run_cycle(0, 0, "t6_rst");
        rst = 1'b0;
        run_cycle(1, 0, "t6_tie");
        set_a(0, 0, 0, 0, 0);
        run_cycle(0, 1, "t6_b");
        set_b(0, 0, 0, 0, 0);
        run_cycle(0, 0, "drain");
        run_cycle(0, 0, "drain2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
